// File: rtl/ioshim_seq.sv
// ioshim_seq: fetch/decode/writeback sequencer feeding the ioshim 8-bit ALU, with handshaked IN/OUT ports.
// Define IOSHIM_SEQ_HALT_EN to add the HALT state and the halted port (BR with bit 11 set stops fetching).
`timescale 1ns/1ps
module ioshim_seq #(
    parameter int PC_BITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_BITS-1:0] imem_addr,
    input  logic [15:0]        imem_data,
    output logic [4:0]         alu_insn,
    output logic [7:0]         alu_op1,
    output logic [7:0]         alu_op2,
    input  logic [7:0]         alu_result,
    output logic [7:0]         io_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic               in_ready,
    input  logic               in_valid,
    input  logic [7:0]         in_data
`ifdef IOSHIM_SEQ_HALT_EN
    ,
    output logic               halted
`endif
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_WB, S_OUT, S_IN
`ifdef IOSHIM_SEQ_HALT_EN
        , S_HALT
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [PC_BITS-1:0] pc_q, pc_d, pc_inc, br_tgt;
    logic [15:0]        ir_q, ir_d;
    logic [7:0]         regs_q [8];
    logic               we;
    logic [2:0]         wa;
    logic [7:0]         wd;

    assign imem_addr = pc_q;
    assign pc_inc    = pc_q + PC_BITS'(1);
    assign br_tgt    = PC_BITS'(imem_data[7:0]);
`ifdef IOSHIM_SEQ_HALT_EN
    assign halted    = (state_q == S_HALT);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            if (we) regs_q[wa] <= wd;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        we        = 1'b0;
        wa        = '0;
        wd        = '0;
        alu_insn  = '0;
        alu_op1   = '0;
        alu_op2   = '0;
        io_addr   = '0;
        out_valid = 1'b0;
        out_data  = '0;
        in_ready  = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_d = imem_data;
                case (imem_data[15:14])
                    2'b00: begin
                        alu_insn = imem_data[13:9];
                        alu_op1  = regs_q[imem_data[5:3]];
                        alu_op2  = regs_q[imem_data[2:0]];
                        state_d  = S_WB;
                    end
                    2'b01: begin
                        // LDI rides through the ALU as op 0 (pass op2)
                        alu_op2 = imem_data[7:0];
                        state_d = S_WB;
                    end
                    2'b10: begin
                        state_d = S_FETCH;
                        pc_d    = (imem_data[12] || regs_q[imem_data[10:8]] != 8'd0) ? br_tgt : pc_inc;
`ifdef IOSHIM_SEQ_HALT_EN
                        if (imem_data[11]) begin
                            state_d = S_HALT;
                            pc_d    = pc_q;
                        end
`endif
                    end
                    default: state_d = imem_data[13] ? S_OUT : S_IN;
                endcase
            end
            S_WB: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                wd      = alu_result;
                if (ir_q[15:14] == 2'b01) begin
                    we = 1'b1;
                    wa = ir_q[10:8];
                end else if (ir_q[13:9] < 5'd27) begin
                    // ALU ops 27..31 are NOPs: skip writeback only
                    we = 1'b1;
                    wa = ir_q[8:6];
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                io_addr   = ir_q[7:0];
                out_data  = regs_q[ir_q[10:8]];
                if (out_ready) begin
                    state_d = S_FETCH;
                    pc_d    = pc_inc;
                end
            end
            S_IN: begin
                in_ready = 1'b1;
                io_addr  = ir_q[7:0];
                if (in_valid) begin
                    we      = 1'b1;
                    wa      = ir_q[10:8];
                    wd      = in_data;
                    state_d = S_FETCH;
                    pc_d    = pc_inc;
                end
            end
            default: state_d = state_q;
        endcase
    end

endmodule

// File: tb/tb_ioshim_seq.sv
// Directed bench for ioshim_seq: behavioural ROM and ALU around an 8-bit-PC instance plus a 4-bit-PC instance.
`timescale 1ns/1ps
module tb_ioshim_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [4:0]  alu_insn;
    logic [7:0]  alu_op1, alu_op2, alu_result, io_addr, out_data, in_data;
    logic        out_valid, out_ready, in_ready, in_valid;

    logic [3:0]  imem_addr4;
    logic [15:0] imem_data4;
    logic [4:0]  alu_insn4;
    logic [7:0]  alu_op1_4, alu_op2_4, io_addr4, out_data4;
    logic [7:0]  alu_result4 = 8'h00;
    logic        out_valid4, in_ready4;
    logic        out_ready4 = 1'b0, in_valid4 = 1'b0;
    logic [7:0]  in_data4 = 8'h00;
`ifdef IOSHIM_SEQ_HALT_EN
    logic        halted, halted4;
`endif

    logic [15:0] rom  [256];
    logic [15:0] rom4 [16];
    int nvec  = 0;
    int nfail = 0;

    ioshim_seq #(.PC_BITS(8)) u_dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .alu_insn(alu_insn), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result),
        .io_addr(io_addr), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data)
`ifdef IOSHIM_SEQ_HALT_EN
        , .halted(halted)
`endif
    );

    ioshim_seq #(.PC_BITS(4)) u_dut4 (
        .clk(clk), .reset(reset), .imem_addr(imem_addr4), .imem_data(imem_data4),
        .alu_insn(alu_insn4), .alu_op1(alu_op1_4), .alu_op2(alu_op2_4), .alu_result(alu_result4),
        .io_addr(io_addr4), .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .in_ready(in_ready4), .in_valid(in_valid4), .in_data(in_data4)
`ifdef IOSHIM_SEQ_HALT_EN
        , .halted(halted4)
`endif
    );

    // ALU model: op0 pass op2, op1 add, op2 sub; anything else yields FF so a bad writeback shows
    function automatic logic [7:0] alu_f(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            5'd0:    return b;
            5'd1:    return a + b;
            5'd2:    return a - b;
            default: return 8'hFF;
        endcase
    endfunction

    always @(posedge clk) begin
        imem_data  <= rom[imem_addr];
        imem_data4 <= rom4[imem_addr4];
        alu_result <= alu_f(alu_insn, alu_op1, alu_op2);
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec++; if (imem_addr !== 8'h00) begin nfail++; $display("FAIL reset_imem_addr got=%h want=00", imem_addr); end
        nvec++; if ({alu_insn, alu_op1, alu_op2} !== 21'h0) begin nfail++; $display("FAIL reset_alu got=%h/%h/%h want=0", alu_insn, alu_op1, alu_op2); end
        nvec++; if ({io_addr, out_data} !== 16'h0) begin nfail++; $display("FAIL reset_io got=%h/%h want=0", io_addr, out_data); end
        nvec++; if ({out_valid, in_ready} !== 2'b00) begin nfail++; $display("FAIL reset_hs got=%b%b want=00", out_valid, in_ready); end
`ifdef IOSHIM_SEQ_HALT_EN
        nvec++; if (halted !== 1'b0) begin nfail++; $display("FAIL reset_halted got=%b want=0", halted); end
`endif
    endtask

    task automatic test_add_out();
        int cyc;
        bit seen;
        clear_rom();
        rom[0] = 16'h4105; rom[1] = 16'h4203; rom[2] = 16'h02CA; rom[3] = 16'hE310; rom[4] = 16'h9004;
        out_ready = 1'b1;
        do_reset();
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            seen = out_valid;
        end
        nvec++; if (cyc != 11) begin nfail++; $display("FAIL add_out_latency got=%0d want=11", cyc); end
        nvec++; if (out_data !== 8'h08) begin nfail++; $display("FAIL add_out_data got=%h want=08", out_data); end
        nvec++; if (io_addr !== 8'h10) begin nfail++; $display("FAIL add_out_addr got=%h want=10", io_addr); end
        @(posedge clk); @(negedge clk);
        nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL add_out_single got=%b want=0", out_valid); end
    endtask

    task automatic test_branch_loop();
        int nsub, nout;
        logic [7:0] d;
        clear_rom();
        rom[0] = 16'h4103; rom[1] = 16'h4201; rom[2] = 16'h044A; rom[3] = 16'h8102;
        rom[4] = 16'hE101; rom[5] = 16'h9005;
        out_ready = 1'b1;
        do_reset();
        nsub = 0; nout = 0; d = 8'hXX;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); @(negedge clk);
            if (alu_insn == 5'd2) nsub++;
            if (out_valid) begin nout++; d = out_data; end
        end
        nvec++; if (nsub != 3) begin nfail++; $display("FAIL loop_sub_count got=%0d want=3", nsub); end
        nvec++; if (nout != 1) begin nfail++; $display("FAIL loop_out_count got=%0d want=1", nout); end
        nvec++; if (d !== 8'h00) begin nfail++; $display("FAIL loop_out_data got=%h want=00", d); end
    endtask

    task automatic test_in_wait();
        int irc, nout;
        logic [7:0] a0, d;
        clear_rom();
        rom[0] = 16'hC420; rom[1] = 16'hE430; rom[2] = 16'h9002;
        out_ready = 1'b1;
        do_reset();
        irc = 0; nout = 0; a0 = 8'hXX; d = 8'hXX;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); @(negedge clk);
            if (in_ready) begin
                irc++;
                if (irc == 1) a0 = io_addr;
                in_valid = (irc == 6);
                in_data  = 8'hA5;
            end else in_valid = 1'b0;
            if (out_valid) begin nout++; d = out_data; end
        end
        in_valid = 1'b0;
        nvec++; if (irc != 6) begin nfail++; $display("FAIL in_ready_cycles got=%0d want=6", irc); end
        nvec++; if (a0 !== 8'h20) begin nfail++; $display("FAIL in_io_addr got=%h want=20", a0); end
        nvec++; if (d !== 8'hA5 || nout != 1) begin nfail++; $display("FAIL in_echo got=%h x%0d want=a5 x1", d, nout); end
    endtask

    task automatic test_out_backpressure();
        int ovc, unstable;
        logic [7:0] d0, a0;
        clear_rom();
        rom[0] = 16'h455C; rom[1] = 16'hE577; rom[2] = 16'h9002;
        out_ready = 1'b0;
        do_reset();
        ovc = 0; unstable = 0; d0 = 8'hXX; a0 = 8'hXX;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid) begin
                ovc++;
                if (ovc == 1) begin d0 = out_data; a0 = io_addr; end
                else if (out_data !== d0 || io_addr !== a0) unstable++;
                out_ready = (ovc == 5);
            end else out_ready = 1'b0;
        end
        nvec++; if (ovc != 5) begin nfail++; $display("FAIL out_valid_cycles got=%0d want=5", ovc); end
        nvec++; if (unstable != 0) begin nfail++; $display("FAIL out_stable got=%0d changes want=0", unstable); end
        nvec++; if ({d0, a0} !== 16'h5C77) begin nfail++; $display("FAIL out_payload got=%h/%h want=5c/77", d0, a0); end
    endtask

    task automatic test_nop();
        int nout;
        logic [7:0] d;
        clear_rom();
        rom[0] = 16'h4642; rom[1] = 16'h3780; rom[2] = 16'hE602; rom[3] = 16'h9003;
        out_ready = 1'b1;
        do_reset();
        nout = 0; d = 8'hXX;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid) begin nout++; d = out_data; end
        end
        nvec++; if (d !== 8'h42 || nout != 1) begin nfail++; $display("FAIL nop_no_wb got=%h x%0d want=42 x1", d, nout); end
    endtask

    task automatic test_reset_in_state();
        int k;
        int nout;
        logic [7:0] d;
        clear_rom();
        rom[0] = 16'hC420; rom[1] = 16'h9001;
        out_ready = 1'b0;
        do_reset();
        k = 0;
        while (!in_ready && k < 10) begin @(posedge clk); @(negedge clk); k++; end
        nvec++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL rst_in_reach got=%b want=1", in_ready); end
        in_valid = 1'b1; in_data = 8'hEE; reset = 1'b1;
        @(posedge clk); @(negedge clk);
        nvec++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        nvec++; if (imem_addr !== 8'h00) begin nfail++; $display("FAIL rst_in_imem_addr got=%h want=00", imem_addr); end
        rom[0] = 16'hE420;
        in_valid = 1'b0; out_ready = 1'b1; reset = 1'b0;
        nout = 0; d = 8'hXX;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid && nout == 0) begin nout++; d = out_data; end
        end
        nvec++; if (d !== 8'h00) begin nfail++; $display("FAIL rst_in_reg got=%h want=00", d); end
    endtask

    task automatic test_pc_wrap();
        for (int i = 0; i < 16; i++) rom4[i] = 16'h3600;
        do_reset();
        for (int k = 1; k <= 48; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == 45) begin
                nvec++; if (imem_addr4 !== 4'hF) begin nfail++; $display("FAIL wrap_pre got=%h want=f", imem_addr4); end
            end
            if (k == 48) begin
                nvec++; if (imem_addr4 !== 4'h0) begin nfail++; $display("FAIL wrap_post got=%h want=0", imem_addr4); end
            end
        end
    endtask

    task automatic test_halt();
        int bad;
        rom4[5] = 16'h9800;
        do_reset();
        repeat (17) begin @(posedge clk); @(negedge clk); end
`ifdef IOSHIM_SEQ_HALT_EN
        nvec++; if (halted4 !== 1'b1) begin nfail++; $display("FAIL halt_flag got=%b want=1", halted4); end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (imem_addr4 !== 4'h5 || halted4 !== 1'b1) bad++;
            @(posedge clk); @(negedge clk);
        end
        nvec++; if (bad != 0) begin nfail++; $display("FAIL halt_hold got=%0d bad cycles want=0", bad); end
`else
        bad = 0;
        nvec++; if (imem_addr4 !== 4'h0) begin nfail++; $display("FAIL halt_ignored got=%h want=0", imem_addr4); end
`endif
    endtask

    initial begin
        test_reset();
        test_add_out();
        test_branch_loop();
        test_in_wait();
        test_out_backpressure();
        test_nop();
        test_reset_in_state();
        test_pc_wrap();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
